// File: rtl/ifu_fetch.sv
// Instruction fetch unit feeding the IF/ID register.
// Issues word reads on a req/gnt/rvalid bus with up to MAX_OUTSTANDING reads
// in flight, buffers responses in a small FIFO and presents them with a
// valid/ready handshake. A jump redirects the PC, flushes the FIFO and marks
// every pending read to be dropped on return.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AQ_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]      fetch_pc;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] drop_cnt;

  logic [31:0]      aq_mem [MAX_OUTSTANDING];
  logic [AQ_W-1:0]  aq_wr;
  logic [AQ_W-1:0]  aq_rd;

  logic [31:0]      fifo_inst [FIFO_DEPTH];
  logic [31:0]      fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic [31:0]      in_use;
  logic             has_space;
  logic             can_issue;
  logic             take;
  logic             dropping;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;

  function automatic logic [AQ_W-1:0] aq_next(input logic [AQ_W-1:0] p);
    return (p == AQ_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit, request and handshake decode
  always_comb begin
    in_use       = 32'(fifo_count) + 32'(outstanding) - 32'(drop_cnt);
    has_space    = in_use < FIFO_DEPTH;
    can_issue    = 32'(outstanding) < MAX_OUTSTANDING;
    fifo_empty   = (fifo_count == '0);
    fifo_full    = (32'(fifo_count) == FIFO_DEPTH);
    // rst_n gating keeps req low while reset is held
    ibus_req_o   = rst_n & ~jump_i & has_space & can_issue;
    ibus_addr_o  = {fetch_pc[31:2], 2'b00};
    take         = ibus_req_o & ibus_gnt_i;
    dropping     = (drop_cnt != '0);
    fifo_push    = ibus_rvalid_i & ~dropping & ~jump_i;
    inst_valid_o = ~fifo_empty & ~jump_i;
    fifo_pop     = inst_valid_o & ready_i;
    inst_o       = fifo_empty ? INST_NOP : fifo_inst[rd_ptr];
    inst_addr_o  = fifo_empty ? '0 : fifo_addr[rd_ptr];
  end

  // Fetch PC, in-flight accounting and the address queue of pending reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) aq_mem[i] <= '0;
    end else begin
      if (jump_i)
        fetch_pc <= {jump_addr_i[31:2], 2'b00};
      else if (take)
        fetch_pc <= fetch_pc + 32'd4;

      outstanding <= outstanding + OUT_W'(take) - OUT_W'(ibus_rvalid_i);

      // a jump-cycle response is discarded either way, so the remaining
      // pending reads are exactly outstanding minus this cycle's rvalid
      if (jump_i)
        drop_cnt <= outstanding - OUT_W'(ibus_rvalid_i);
      else if (ibus_rvalid_i && dropping)
        drop_cnt <= drop_cnt - 1'b1;

      if (take) begin
        aq_mem[aq_wr] <= fetch_pc;
        aq_wr         <= aq_next(aq_wr);
      end
      if (ibus_rvalid_i)
        aq_rd <= aq_next(aq_rd);
    end
  end

  // Instruction FIFO with flush on jump
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else if (jump_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        fifo_inst[wr_ptr] <= ibus_rdata_i;
        fifo_addr[wr_ptr] <= aq_mem[aq_rd];
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (fifo_pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end
  end

  // Credit accounting must never let a push land in a full FIFO
  always_ff @(posedge clk) begin
    if (rst_n)
      assert (!(fifo_push && fifo_full && !fifo_pop));
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed phases plus a random phase,
// checked every cycle against a queue-based reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          MAXO     = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  ifu_fetch #(
    .RESET_PC(RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .jump_i(jump_i),
    .jump_addr_i(jump_addr_i),
    .ibus_req_o(ibus_req_o),
    .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i(ibus_rdata_i),
    .ready_i(ready_i),
    .inst_o(inst_o),
    .inst_addr_o(inst_addr_o),
    .inst_valid_o(inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          drop;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  // reference model: fetch PC, reads in flight (oldest first), delivered FIFO
  logic [31:0] m_pc;
  pend_t       pend[$];
  ent_t        mfifo[$];
  // bus environment: addresses granted but not yet answered
  logic [31:0] bus_q[$];

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    pend.delete();
    mfifo.delete();
    bus_q.delete();
  endtask

  // Asserts reset away from any clock edge and checks outputs respond at once
  task automatic do_reset();
    jump_i        = 1'b0;
    jump_addr_i   = '0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = '0;
    ready_i       = 1'b1;
    rst_n         = 1'b0;
    #1;
    check("rst_req", 32'(ibus_req_o), 32'd0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_iaddr", inst_addr_o, 32'd0);
    check("rst_addr", ibus_addr_o, RESET_PC);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model
  task automatic step(input bit j, input logic [31:0] ja, input bit g, input bit rv, input bit rdy);
    bit    exp_req;
    bit    exp_valid;
    int    keep;
    pend_t p;
    ent_t  e;
    jump_i        = j;
    jump_addr_i   = ja;
    ibus_gnt_i    = g;
    ready_i       = rdy;
    ibus_rvalid_i = rv && (bus_q.size() > 0);
    ibus_rdata_i  = ibus_rvalid_i ? mem(bus_q[0]) : $urandom;
    @(negedge clk);

    keep = 0;
    foreach (pend[i]) if (!pend[i].drop) keep++;
    exp_req   = !j && (mfifo.size() + keep < DEPTH) && (pend.size() < MAXO);
    exp_valid = (mfifo.size() > 0) && !j;

    check("req", 32'(ibus_req_o), 32'(exp_req));
    if (exp_req) check("addr", ibus_addr_o, m_pc);
    check("valid", 32'(inst_valid_o), 32'(exp_valid));
    check("inst", inst_o, (mfifo.size() > 0) ? mfifo[0].data : NOP);
    check("iaddr", inst_addr_o, (mfifo.size() > 0) ? mfifo[0].addr : 32'd0);

    if (ibus_rvalid_i) void'(bus_q.pop_front());
    if (ibus_req_o && g) bus_q.push_back(ibus_addr_o);

    if (exp_valid && rdy) void'(mfifo.pop_front());
    if (ibus_rvalid_i && pend.size() > 0) begin
      p = pend.pop_front();
      if (!p.drop && !j) begin
        e.addr = p.addr;
        e.data = ibus_rdata_i;
        mfifo.push_back(e);
      end
    end
    if (exp_req && g) begin
      p.addr = m_pc;
      p.drop = 1'b0;
      pend.push_back(p);
      m_pc = m_pc + 32'd4;
    end
    if (j) begin
      mfifo.delete();
      foreach (pend[i]) pend[i].drop = 1'b1;
      m_pc = {ja[31:2], 2'b00};
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ja;
    rst_n = 1'b0;
    do_reset();

    // zero-wait bus, downstream always ready
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // downstream stalls for 10 cycles from a fresh start, then drains
    do_reset();
    repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // two reads in flight, then redirect to an unaligned target
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0103, 1'b0, 1'b0, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // jump coinciding with a response while another read is pending
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // grant withheld with one read pending, then grant and rvalid together
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // PC wrap across 2^32
    step(1'b1, 32'hFFFF_FFF9, 1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // fill the FIFO, then reset mid-stream
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    do_reset();
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // randomized traffic, including back-to-back jumps
    repeat (2000) begin
      ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 11) == 0, ja,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
